// File: rtl/cdb_rr_arbiter_pkg.sv
// Shared definitions for the CDB round-robin arbiter slice: default widths,
// the broadcast packet layout and small width helpers.
package cdb_rr_arbiter_pkg;

  localparam int NUM_SRC_DEF = 8;   // completion sources (FU result ports)
  localparam int N_LANE_DEF  = 4;   // CDB lanes per cycle
  localparam int PRN_W_DEF   = 6;   // physical register tag width
  localparam int ROBN_W_DEF  = 5;   // ROB index width
  localparam int DATA_W_DEF  = 32;  // result value width

  // One CDB broadcast at the default widths.
  typedef struct packed {
    logic [PRN_W_DEF-1:0]  prn;
    logic [ROBN_W_DEF-1:0] robn;
    logic [DATA_W_DEF-1:0] value;
  } cdb_packet_t;

  // Index width for n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that has to hold 0..n_lane inclusive.
  function automatic int count_width(input int n_lane);
    return $clog2(n_lane + 1);
  endfunction

endpackage

// File: rtl/cdb_rr_arbiter_if.sv
// Source-side request bus and CDB broadcast bus of the completion arbiter.
// The master side is the set of functional units plus the CDB consumers,
// the slave side is the arbiter itself.
interface cdb_rr_arbiter_if #(
  parameter int NUM_SRC = cdb_rr_arbiter_pkg::NUM_SRC_DEF,
  parameter int N_LANE  = cdb_rr_arbiter_pkg::N_LANE_DEF,
  parameter int PRN_W   = cdb_rr_arbiter_pkg::PRN_W_DEF,
  parameter int ROBN_W  = cdb_rr_arbiter_pkg::ROBN_W_DEF,
  parameter int DATA_W  = cdb_rr_arbiter_pkg::DATA_W_DEF
);
  import cdb_rr_arbiter_pkg::*;

  localparam int CNT_W = count_width(N_LANE);

  // pipeline flush from branch recovery
  logic                       squash;

  // completion requests, one slot per source, flattened source-major
  logic [NUM_SRC-1:0]         src_valid;
  logic [NUM_SRC*PRN_W-1:0]   src_prn;
  logic [NUM_SRC*ROBN_W-1:0]  src_robn;
  logic [NUM_SRC*DATA_W-1:0]  src_value;
  logic [NUM_SRC-1:0]         src_ready;

  // registered broadcast, flattened lane-major
  logic [N_LANE-1:0]          cdb_valid;
  logic [N_LANE*PRN_W-1:0]    cdb_prn;
  logic [N_LANE*ROBN_W-1:0]   cdb_robn;
  logic [N_LANE*DATA_W-1:0]   cdb_value;
  logic [CNT_W-1:0]           cdb_count;

  modport master (
    output squash, src_valid, src_prn, src_robn, src_value,
    input  src_ready, cdb_valid, cdb_prn, cdb_robn, cdb_value, cdb_count
  );

  modport slave (
    input  squash, src_valid, src_prn, src_robn, src_value,
    output src_ready, cdb_valid, cdb_prn, cdb_robn, cdb_value, cdb_count
  );

endinterface

// File: rtl/cdb_rr_arbiter_rr_multi_select.sv
// Purely combinational multi-grant round-robin selector: rotates the request
// vector so that ptr becomes position 0, picks the first N_LANE set bits in
// ascending order, and maps the picks back to source indices. Lane k receives
// the k-th pick, so lanes come out in scan order.
module cdb_rr_arbiter_rr_multi_select #(
  parameter int NUM_SRC = cdb_rr_arbiter_pkg::NUM_SRC_DEF,
  parameter int N_LANE  = cdb_rr_arbiter_pkg::N_LANE_DEF,
  localparam int IDX_W  = cdb_rr_arbiter_pkg::idx_width(NUM_SRC),
  localparam int CNT_W  = cdb_rr_arbiter_pkg::count_width(N_LANE)
) (
  input  logic                         enable,       // 0 forces an empty grant
  input  logic [NUM_SRC-1:0]           req,
  input  logic [IDX_W-1:0]             ptr,          // first source to scan
  output logic [NUM_SRC-1:0]           grant,
  output logic [N_LANE-1:0]            lane_valid,
  output logic [N_LANE-1:0][IDX_W-1:0] lane_src,     // source index per lane
  output logic [IDX_W-1:0]             last_idx,     // last granted source
  output logic [CNT_W-1:0]             grant_count
);
  import cdb_rr_arbiter_pkg::*;

  // rot_idx[j] is the source scanned in position j, i.e. (ptr + j) mod NUM_SRC
  logic [NUM_SRC-1:0][IDX_W-1:0] rot_idx;
  logic [NUM_SRC-1:0]            rot_req;
  logic [NUM_SRC-1:0]            rot_grant;
  logic [N_LANE-1:0][IDX_W-1:0]  lane_pos;
  logic [IDX_W-1:0]              last_pos;

  genvar gi;

  // Rotate: scan position -> source index, wrapping without a divider.
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : gen_rot
      logic [IDX_W:0] sum;
      assign sum         = {1'b0, ptr} + (IDX_W+1)'(gi);
      assign rot_idx[gi] = (sum >= (IDX_W+1)'(NUM_SRC))
                         ? IDX_W'(sum - (IDX_W+1)'(NUM_SRC))
                         : sum[IDX_W-1:0];
      assign rot_req[gi] = enable & req[rot_idx[gi]];
    end
  endgenerate

  // Pick: first N_LANE requesting positions in rotated order, one per lane.
  always_comb begin
    int cnt;
    cnt        = 0;
    rot_grant  = '0;
    lane_valid = '0;
    lane_pos   = '0;
    last_pos   = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      if (rot_req[j] && (cnt < N_LANE)) begin
        rot_grant[j] = 1'b1;
        for (int k = 0; k < N_LANE; k++) begin
          if (k == cnt) begin
            lane_valid[k] = 1'b1;
            lane_pos[k]   = IDX_W'(j);
          end
        end
        last_pos = IDX_W'(j);
        cnt      = cnt + 1;
      end
    end
    grant_count = CNT_W'(cnt);
  end

  // Unrotate: scatter rotated grants back onto their source indices.
  always_comb begin
    grant = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      if (rot_grant[j]) begin
        grant[rot_idx[j]] = 1'b1;
      end
    end
  end

  // Lane source indices and the pointer anchor in source numbering.
  generate
    for (gi = 0; gi < N_LANE; gi++) begin : gen_lane_src
      assign lane_src[gi] = lane_valid[gi] ? rot_idx[lane_pos[gi]] : '0;
    end
  endgenerate

  assign last_idx = rot_idx[last_pos];

endmodule

// File: rtl/cdb_rr_arbiter.sv
// Common data bus completion arbiter. Up to N_LANE of NUM_SRC finished
// results are granted each cycle under a rotating priority and broadcast on
// the CDB lanes from a register one cycle later. The rotation pointer moves
// just past the last granted source, which bounds any continuously valid
// source's wait to ceil(NUM_SRC/N_LANE) cycles.
module cdb_rr_arbiter #(
  parameter int NUM_SRC = cdb_rr_arbiter_pkg::NUM_SRC_DEF,
  parameter int N_LANE  = cdb_rr_arbiter_pkg::N_LANE_DEF,
  parameter int PRN_W   = cdb_rr_arbiter_pkg::PRN_W_DEF,
  parameter int ROBN_W  = cdb_rr_arbiter_pkg::ROBN_W_DEF,
  parameter int DATA_W  = cdb_rr_arbiter_pkg::DATA_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  cdb_rr_arbiter_if.slave  bus
);
  import cdb_rr_arbiter_pkg::*;

  localparam int IDX_W = idx_width(NUM_SRC);
  localparam int CNT_W = count_width(N_LANE);

  // per-source payload views of the flattened request bus
  logic [NUM_SRC-1:0][PRN_W-1:0]  src_prn_arr;
  logic [NUM_SRC-1:0][ROBN_W-1:0] src_robn_arr;
  logic [NUM_SRC-1:0][DATA_W-1:0] src_value_arr;

  // selector results
  logic                           sel_enable;
  logic [NUM_SRC-1:0]             grant;
  logic [N_LANE-1:0]              lane_valid;
  logic [N_LANE-1:0][IDX_W-1:0]   lane_src;
  logic [IDX_W-1:0]               last_idx;
  logic [CNT_W-1:0]               grant_count;

  // next-state values
  logic [IDX_W:0]                 ptr_inc;
  logic [IDX_W-1:0]               rr_ptr_next;
  logic [N_LANE-1:0][PRN_W-1:0]   cdb_prn_next;
  logic [N_LANE-1:0][ROBN_W-1:0]  cdb_robn_next;
  logic [N_LANE-1:0][DATA_W-1:0]  cdb_value_next;

  // state
  logic [IDX_W-1:0]               rr_ptr_reg;
  logic [N_LANE-1:0]              cdb_valid_reg;
  logic [N_LANE-1:0][PRN_W-1:0]   cdb_prn_reg;
  logic [N_LANE-1:0][ROBN_W-1:0]  cdb_robn_reg;
  logic [N_LANE-1:0][DATA_W-1:0]  cdb_value_reg;
  logic [CNT_W-1:0]               cdb_count_reg;

  genvar gi;

  assign src_prn_arr   = bus.src_prn;
  assign src_robn_arr  = bus.src_robn;
  assign src_value_arr = bus.src_value;

  // No grants while a flush is in progress or the block is held in reset.
  assign sel_enable = ~bus.squash & ~reset;

  cdb_rr_arbiter_rr_multi_select #(
    .NUM_SRC (NUM_SRC),
    .N_LANE  (N_LANE)
  ) u_select (
    .enable      (sel_enable),
    .req         (bus.src_valid),
    .ptr         (rr_ptr_reg),
    .grant       (grant),
    .lane_valid  (lane_valid),
    .lane_src    (lane_src),
    .last_idx    (last_idx),
    .grant_count (grant_count)
  );

  assign bus.src_ready = grant;

  // Pointer resumes the scan just after the last source served this cycle.
  assign ptr_inc     = {1'b0, last_idx} + (IDX_W+1)'(1);
  assign rr_ptr_next = (ptr_inc == (IDX_W+1)'(NUM_SRC)) ? '0 : ptr_inc[IDX_W-1:0];

  // Lane payload mux; unused lanes carry zeros so consumers never see stale data.
  generate
    for (gi = 0; gi < N_LANE; gi++) begin : gen_lane_mux
      assign cdb_prn_next[gi]   = lane_valid[gi] ? src_prn_arr[lane_src[gi]]   : '0;
      assign cdb_robn_next[gi]  = lane_valid[gi] ? src_robn_arr[lane_src[gi]]  : '0;
      assign cdb_value_next[gi] = lane_valid[gi] ? src_value_arr[lane_src[gi]] : '0;
    end
  endgenerate

  // Broadcast register and rotation pointer; squash empties the bus and
  // restarts the scan at source 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr_reg    <= '0;
      cdb_valid_reg <= '0;
      cdb_prn_reg   <= '0;
      cdb_robn_reg  <= '0;
      cdb_value_reg <= '0;
      cdb_count_reg <= '0;
    end else if (bus.squash) begin
      rr_ptr_reg    <= '0;
      cdb_valid_reg <= '0;
      cdb_prn_reg   <= '0;
      cdb_robn_reg  <= '0;
      cdb_value_reg <= '0;
      cdb_count_reg <= '0;
    end else begin
      cdb_valid_reg <= lane_valid;
      cdb_prn_reg   <= cdb_prn_next;
      cdb_robn_reg  <= cdb_robn_next;
      cdb_value_reg <= cdb_value_next;
      cdb_count_reg <= grant_count;
      if (|grant) begin
        rr_ptr_reg <= rr_ptr_next;
      end
    end
  end

  assign bus.cdb_valid = cdb_valid_reg;
  assign bus.cdb_prn   = cdb_prn_reg;
  assign bus.cdb_robn  = cdb_robn_reg;
  assign bus.cdb_value = cdb_value_reg;
  assign bus.cdb_count = cdb_count_reg;

endmodule

// File: tb/tb_cdb_rr_arbiter.sv
// Directed and randomized bench for cdb_rr_arbiter (8 sources, 4 lanes).
// A reference model holds each source's pending result and the rotation
// pointer, derives the expected grant set from the scan rule and checks
// src_ready, the registered lanes, cdb_count and the wait bound.
module tb_cdb_rr_arbiter;
  import cdb_rr_arbiter_pkg::*;

  localparam int NS = 8;
  localparam int NL = 4;
  localparam int PW = 6;
  localparam int RW = 5;
  localparam int DW = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  cdb_rr_arbiter_if #(.NUM_SRC(NS), .N_LANE(NL), .PRN_W(PW), .ROBN_W(RW), .DATA_W(DW)) bus ();

  cdb_rr_arbiter #(.NUM_SRC(NS), .N_LANE(NL), .PRN_W(PW), .ROBN_W(RW), .DATA_W(DW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // reference model state
  bit          m_pend [NS];
  cdb_packet_t m_pkt  [NS];
  int          m_wait [NS];
  int          m_ptr;
  logic        sq;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_src(input int i, input int prn, input int robn, input int val);
    m_pend[i]       = 1'b1;
    m_pkt[i].prn    = PW'(prn);
    m_pkt[i].robn   = RW'(robn);
    m_pkt[i].value  = DW'(val);
  endtask

  task automatic rand_src(input int i);
    int prn;
    prn = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 63));
    set_src(i, prn, int'($urandom_range(0, 31)), int'($urandom));
  endtask

  task automatic clear_srcs();
    for (int i = 0; i < NS; i++) begin
      m_pend[i] = 1'b0;
      m_wait[i] = 0;
    end
  endtask

  task automatic drive();
    bus.squash = sq;
    for (int i = 0; i < NS; i++) begin
      bus.src_valid[i]             = m_pend[i];
      bus.src_prn[i*PW +: PW]      = m_pkt[i].prn;
      bus.src_robn[i*RW +: RW]     = m_pkt[i].robn;
      bus.src_value[i*DW +: DW]    = m_pkt[i].value;
    end
  endtask

  // One arbitration cycle: drive, check grants, clock, check broadcast,
  // then advance the model.
  task automatic cycle(input string tag);
    int          gq[$];
    logic [NS-1:0] exp_ready;
    logic [NS-1:0] obs_ready;
    logic [NL-1:0] exp_valid;
    drive();
    #2;
    exp_ready = '0;
    if (!sq) begin
      for (int k = 0; k < NS; k++) begin
        int s;
        s = (m_ptr + k) % NS;
        if (m_pend[s] && gq.size() < NL) gq.push_back(s);
      end
    end
    foreach (gq[q]) exp_ready[gq[q]] = 1'b1;
    obs_ready = bus.src_ready;
    chk({tag, ".ready"}, 64'(obs_ready), 64'(exp_ready));
    if (!sq) begin
      for (int i = 0; i < NS; i++) begin
        if (m_pend[i] && obs_ready[i])
          chk($sformatf("%s.fair%0d", tag, i), 64'(m_wait[i] <= 1), 64'(1));
      end
    end
    @(posedge clock);
    #1;
    exp_valid = '0;
    for (int l = 0; l < gq.size(); l++) exp_valid[l] = 1'b1;
    chk({tag, ".cdb_valid"}, 64'(bus.cdb_valid), 64'(exp_valid));
    chk({tag, ".cdb_count"}, 64'(bus.cdb_count), 64'(gq.size()));
    for (int l = 0; l < NL; l++) begin
      cdb_packet_t e;
      e = '0;
      if (l < gq.size()) e = m_pkt[gq[l]];
      chk($sformatf("%s.l%0d.prn", tag, l),   64'(bus.cdb_prn[l*PW +: PW]),   64'(e.prn));
      chk($sformatf("%s.l%0d.robn", tag, l),  64'(bus.cdb_robn[l*RW +: RW]),  64'(e.robn));
      chk($sformatf("%s.l%0d.value", tag, l), 64'(bus.cdb_value[l*DW +: DW]), 64'(e.value));
    end
    if (sq) begin
      m_ptr = 0;
      for (int i = 0; i < NS; i++) m_wait[i] = 0;
    end else begin
      for (int i = 0; i < NS; i++)
        if (m_pend[i] && !obs_ready[i]) m_wait[i]++;
      foreach (gq[q]) begin
        m_pend[gq[q]] = 1'b0;
        m_wait[gq[q]] = 0;
      end
      if (gq.size() > 0) m_ptr = (gq[gq.size()-1] + 1) % NS;
    end
    $display("cycle %s grants=%0d ptr=%0d", tag, gq.size(), m_ptr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    sq = 1'b0;
    m_ptr = 0;
    for (int i = 0; i < NS; i++) m_pkt[i] = '0;
    clear_srcs();
    drive();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    // reset state, with a request present that must not be granted
    set_src(0, 7, 1, 99);
    drive();
    #1;
    chk("rst.ready", 64'(bus.src_ready), 64'(0));
    chk("rst.cdb_valid", 64'(bus.cdb_valid), 64'(0));
    chk("rst.cdb_count", 64'(bus.cdb_count), 64'(0));
    chk("rst.cdb_prn", 64'(bus.cdb_prn), 64'(0));
    chk("rst.cdb_value", 64'(bus.cdb_value[31:0]), 64'(0));
    clear_srcs();
    drive();
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    m_ptr = 0;

    // 1: three low sources from pointer 0
    set_src(0, 1, 0, 10);
    set_src(1, 2, 1, 20);
    set_src(2, 3, 2, 30);
    cycle("t1");

    // 2: all sources held valid for three cycles
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NS; i++) if (!m_pend[i]) rand_src(i);
      cycle($sformatf("t2.%0d", r));
    end

    // 4: squash with 3..7 requesting, then resume from pointer 0
    clear_srcs();
    for (int i = 3; i < NS; i++) rand_src(i);
    sq = 1'b1;
    cycle("t4.squash");
    sq = 1'b0;
    cycle("t4.resume");
    cycle("t4.drain");

    // 3: walk pointer to 6, then 1 and 7 requesting wrap in scan order
    for (int i = 0; i < 6; i++) rand_src(i);
    cycle("t3.a");
    cycle("t3.b");
    rand_src(1);
    rand_src(7);
    cycle("t3.wrap");

    // 5: destination-less result still broadcasts
    set_src(2, 0, 9, 25);
    cycle("t5.prn0");

    // 6: asynchronous reset while four lanes are live
    for (int i = 0; i < NS; i++) if (!m_pend[i]) rand_src(i);
    cycle("t6.fill");
    #2;
    reset = 1'b1;
    #1;
    chk("t6.async.cdb_valid", 64'(bus.cdb_valid), 64'(0));
    chk("t6.async.cdb_count", 64'(bus.cdb_count), 64'(0));
    chk("t6.async.cdb_prn", 64'(bus.cdb_prn), 64'(0));
    chk("t6.async.ready", 64'(bus.src_ready), 64'(0));
    clear_srcs();
    m_ptr = 0;
    set_src(5, 12, 4, 555);
    drive();
    #1;
    reset = 1'b0;
    cycle("t6.src5");

    // randomized traffic with occasional flushes
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NS; i++)
        if (!m_pend[i] && $urandom_range(0, 99) < 45) rand_src(i);
      sq = ($urandom_range(0, 99) < 6);
      cycle($sformatf("rnd%0d", n));
    end
    sq = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
